// File: rtl/operand_issue.sv
// operand_issue: single-issue operand fetch stage for the 16-bit execute units.
// Latches one instruction, reads A/B from an 8x16 register file, hands A/B/op to
// execute over valid/ready, waits for the result and writes it back to R[rd].
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   instr, instr_valid    instruction word {op, rd, rs, rt} / imm6 in [5:0]
//   instr_ready           stage is idle and can accept an instruction
//   A, B, op, ex_valid    operands and opcode presented to execute
//   ex_ready              execute accepts A/B/op
//   res, res_valid        execute result
//   res_ready             stage is waiting for a result
//   dbg_addr, dbg_data    combinational register-file read port (no bypass)
//   busy                  high in every state except IDLE
//
// Build option: define R0_ZERO_EN to hardwire R0 to zero (writes to R0 dropped).
module operand_issue (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   output logic [15:0] A,
   output logic [15:0] B,
   output logic [3:0]  op,
   output logic        ex_valid,
   input  logic        ex_ready,
   input  logic [15:0] res,
   input  logic        res_valid,
   output logic        res_ready,
   input  logic [2:0]  dbg_addr,
   output logic [15:0] dbg_data,
   output logic        busy
);

   localparam int unsigned DW = 16;
   localparam int unsigned NR = 8;
   localparam logic [3:0]  OP_NOP = 4'hF;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;

   logic [2:0]    r_state;
   logic [2:0]    w_next;
   logic [15:0]   r_instr;
   logic [15:0]   r_res;
   logic [15:0]   r_a;
   logic [15:0]   r_b;
   logic [3:0]    r_op;
   logic          r_instr_ready;
   logic          r_ex_valid;
   logic          r_res_ready;
   logic          r_busy;
   logic [DW-1:0] r_rf [NR];

   logic [3:0]    w_op;
   logic [2:0]    w_rd;
   logic [2:0]    w_rs;
   logic [2:0]    w_rt;
   logic [5:0]    w_imm;
   logic          w_wr_en;

   assign w_op  = r_instr[15:12];
   assign w_rd  = r_instr[11:9];
   assign w_rs  = r_instr[8:6];
   assign w_rt  = r_instr[5:3];
   assign w_imm = r_instr[5:0];

`ifdef R0_ZERO_EN
   // R0 is never written, so it keeps its reset value of zero.
   assign w_wr_en = (w_rd != 3'd0);
`else
   assign w_wr_en = 1'b1;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (instr_valid) w_next = S_READ;
         S_READ:  w_next = (w_op == OP_NOP) ? S_IDLE : S_ISSUE;
         S_ISSUE: if (ex_ready) w_next = S_WAIT;
         S_WAIT:  if (res_valid) w_next = S_WRITE;
         S_WRITE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Handshake outputs: registered decodes of the next state. instr_ready
   // resets low so it reads 0 while rst_n is held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr_ready <= 1'b0;
         r_ex_valid    <= 1'b0;
         r_res_ready   <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_instr_ready <= (w_next == S_IDLE);
         r_ex_valid    <= (w_next == S_ISSUE);
         r_res_ready   <= (w_next == S_WAIT);
         r_busy        <= (w_next != S_IDLE);
      end
   end

   // Instruction/result capture and operand registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr <= '0;
         r_res   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= '0;
      end else begin
         if (r_state == S_IDLE && instr_valid) r_instr <= instr;
         if (r_state == S_READ) begin
            r_op <= w_op;
            r_a  <= r_rf[w_rs];
            r_b  <= w_op[3] ? {10'b0, w_imm} : r_rf[w_rt];
         end
         if (r_state == S_WAIT && res_valid) r_res <= res;
      end
   end

   // Register file writeback
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NR); i++) r_rf[i] <= '0;
      end else if (r_state == S_WRITE && w_wr_en) begin
         r_rf[w_rd] <= r_res;
      end
   end

   assign instr_ready = r_instr_ready;
   assign ex_valid    = r_ex_valid;
   assign res_ready   = r_res_ready;
   assign busy        = r_busy;
   assign A           = r_a;
   assign B           = r_b;
   assign op          = r_op;
   assign dbg_data    = r_rf[dbg_addr];

endmodule

// File: tb/tb_operand_issue.sv
// Self-checking bench for operand_issue: directed scenarios plus randomized
// instructions checked against an array model of the register file.
module tb_operand_issue;

   logic        clk;
   logic        rst_n;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] A;
   logic [15:0] B;
   logic [3:0]  op;
   logic        ex_valid;
   logic        ex_ready;
   logic [15:0] res;
   logic        res_valid;
   logic        res_ready;
   logic [2:0]  dbg_addr;
   logic [15:0] dbg_data;
   logic        busy;

   int n_cmp;
   int n_err;
   logic [15:0] m_rf [8];

   operand_issue dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .A(A), .B(B), .op(op), .ex_valid(ex_valid),
      .ex_ready(ex_ready), .res(res), .res_valid(res_valid), .res_ready(res_ready),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Runs one instruction through the stage, starting at a negedge in IDLE.
   task automatic issue_instr(input logic [15:0] ins, input logic [15:0] r,
                              input int exd, input int rsd, input bit spur);
      logic [3:0]  e_op;
      logic [2:0]  e_rd;
      logic [15:0] e_a;
      logic [15:0] e_b;
      e_op = ins[15:12];
      e_rd = ins[11:9];
      e_a  = m_rf[ins[8:6]];
      e_b  = e_op[3] ? {10'b0, ins[5:0]} : m_rf[ins[5:3]];

      instr = ins; instr_valid = 1'b1; ex_ready = 1'b0; res_valid = 1'b0;
      @(negedge clk);                                   // cycle 1: READ
      instr_valid = 1'b0; instr = 16'($urandom);
      n_cmp++;
      if (busy !== 1'b1 || instr_ready !== 1'b0 || ex_valid !== 1'b0) begin
         n_err++;
         $display("FAIL read_cycle: busy=%b rdy=%b exv=%b, need 1/0/0", busy, instr_ready, ex_valid);
      end
      @(negedge clk);                                   // cycle 2
      if (e_op == 4'hF) begin
         n_cmp++;
         if (instr_ready !== 1'b1 || busy !== 1'b0 || ex_valid !== 1'b0) begin
            n_err++;
            $display("FAIL nop_idle: rdy=%b busy=%b exv=%b, need 1/0/0", instr_ready, busy, ex_valid);
         end
      end else begin
         for (int i = 0; i < exd; i++) begin
            n_cmp++;
            if (ex_valid !== 1'b1 || A !== e_a || B !== e_b || op !== e_op ||
                instr_ready !== 1'b0 || res_ready !== 1'b0) begin
               n_err++;
               $display("FAIL issue_hold: exv=%b A=%h B=%h op=%h rdy=%b rr=%b, need 1 %h %h %h 0 0",
                        ex_valid, A, B, op, instr_ready, res_ready, e_a, e_b, e_op);
            end
            res_valid = spur; res = 16'($urandom);
            @(negedge clk);
         end
         n_cmp++;
         if (ex_valid !== 1'b1 || A !== e_a || B !== e_b || op !== e_op) begin
            n_err++;
            $display("FAIL issue: exv=%b A=%h B=%h op=%h, need 1 %h %h %h", ex_valid, A, B, op, e_a, e_b, e_op);
         end
         ex_ready = 1'b1; res_valid = 1'b0;
         @(negedge clk);                                // first WAIT cycle
         ex_ready = 1'b0;
         n_cmp++;
         if (ex_valid !== 1'b0 || res_ready !== 1'b1) begin
            n_err++;
            $display("FAIL wait_entry: exv=%b rr=%b, need 0/1", ex_valid, res_ready);
         end
         for (int i = 0; i < rsd; i++) begin
            @(negedge clk);
            n_cmp++;
            if (res_ready !== 1'b1 || busy !== 1'b1) begin
               n_err++;
               $display("FAIL wait_hold: rr=%b busy=%b, need 1/1", res_ready, busy);
            end
         end
         res_valid = 1'b1; res = r;
         @(negedge clk);                                // WRITE
         res_valid = 1'b0; res = 16'($urandom);
         dbg_addr = e_rd;
         #1;
         n_cmp++;
         if (res_ready !== 1'b0 || busy !== 1'b1 || dbg_data !== m_rf[e_rd]) begin
            n_err++;
            $display("FAIL write_cycle: rr=%b busy=%b dbg=%h, need 0 1 %h", res_ready, busy, dbg_data, m_rf[e_rd]);
         end
`ifdef R0_ZERO_EN
         if (e_rd != 3'd0) m_rf[e_rd] = r;
`else
         m_rf[e_rd] = r;
`endif
         @(negedge clk);                                // back in IDLE
         n_cmp++;
         if (instr_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_return: rdy=%b busy=%b, need 1/0", instr_ready, busy);
         end
      end
      for (int a = 0; a < 8; a++) begin
         dbg_addr = 3'(a);
         #1;
         n_cmp++;
         if (dbg_data !== m_rf[a]) begin
            n_err++;
            $display("FAIL regfile R%0d: got %h need %h", a, dbg_data, m_rf[a]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         instr = 16'($urandom); instr_valid = 1'($urandom); ex_ready = 1'($urandom);
         res = 16'($urandom); res_valid = 1'($urandom); dbg_addr = 3'($urandom);
         @(negedge clk);
         n_cmp++;
         if (instr_ready !== 1'b0 || ex_valid !== 1'b0 || res_ready !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL in_reset: rdy=%b exv=%b rr=%b busy=%b, need all 0", instr_ready, ex_valid, res_ready, busy);
         end
      end
      instr_valid = 1'b0; ex_ready = 1'b0; res_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (instr_ready !== 1'b1 || ex_valid !== 1'b0 || busy !== 1'b0 ||
          A !== 16'h0 || B !== 16'h0 || op !== 4'h0) begin
         n_err++;
         $display("FAIL after_reset: rdy=%b exv=%b busy=%b A=%h B=%h op=%h, need 1 0 0 0 0 0",
                  instr_ready, ex_valid, busy, A, B, op);
      end
      for (int a = 0; a < 8; a++) begin
         m_rf[a] = 16'h0;
         dbg_addr = 3'(a);
         #1;
         n_cmp++;
         if (dbg_data !== 16'h0) begin
            n_err++;
            $display("FAIL reset_rf R%0d: got %h need 0000", a, dbg_data);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_immediate();
      issue_instr(16'h8205, 16'h0020, 0, 0, 1'b0);
      dbg_addr = 3'd1;
      #1;
      n_cmp++;
      if (dbg_data !== 16'h0020) begin
         n_err++;
         $display("FAIL imm_r1: got %h need 0020", dbg_data);
      end
      @(negedge clk);
   endtask

   task automatic test_register_form();
      issue_instr({4'h0, 3'd2, 3'd0, 3'd0, 3'd0}, 16'h0003, 0, 0, 1'b0);
      issue_instr({4'h0, 3'd3, 3'd0, 3'd0, 3'd0}, 16'h0004, 1, 2, 1'b0);
      // m_rf[2]/m_rf[3] now 3/4, so issue_instr expects A=3, B=4
      issue_instr({4'h1, 3'd4, 3'd2, 3'd3, 3'd0}, 16'h1234, 0, 1, 1'b0);
      dbg_addr = 3'd4;
      #1;
      n_cmp++;
      if (dbg_data !== 16'h1234) begin
         n_err++;
         $display("FAIL regform_r4: got %h need 1234", dbg_data);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      issue_instr({4'h2, 3'd5, 3'd3, 3'd2, 3'd0}, 16'hA5A5, 7, 1, 1'b1);
   endtask

   task automatic test_midop_reset();
      instr = {4'h3, 3'd6, 3'd2, 3'd3, 3'd0}; instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      ex_ready = 1'b1;
      @(negedge clk);                                   // WAIT
      ex_ready = 1'b0;
      n_cmp++;
      if (res_ready !== 1'b1) begin
         n_err++;
         $display("FAIL midop_wait: rr=%b need 1", res_ready);
      end
      res = 16'hBEEF; res_valid = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (res_ready !== 1'b0 || ex_valid !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL midop_async: rr=%b exv=%b busy=%b, need 0/0/0", res_ready, ex_valid, busy);
      end
      @(negedge clk);
      res_valid = 1'b0;
      rst_n = 1'b1;
      for (int a = 0; a < 8; a++) m_rf[a] = 16'h0;
      @(negedge clk);
      n_cmp++;
      if (instr_ready !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL midop_idle: rdy=%b busy=%b, need 1/0", instr_ready, busy);
      end
      for (int a = 0; a < 8; a++) begin
         dbg_addr = 3'(a);
         #1;
         n_cmp++;
         if (dbg_data !== 16'h0) begin
            n_err++;
            $display("FAIL midop_rf R%0d: got %h need 0000", a, dbg_data);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_r0();
      logic [15:0] exp_r0;
`ifdef R0_ZERO_EN
      exp_r0 = 16'h0000;
`else
      exp_r0 = 16'hFFFF;
`endif
      issue_instr(16'h0000, 16'hFFFF, 0, 0, 1'b0);
      dbg_addr = 3'd0;
      #1;
      n_cmp++;
      if (dbg_data !== exp_r0) begin
         n_err++;
         $display("FAIL r0_write: got %h need %h", dbg_data, exp_r0);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      for (int k = 0; k < 25; k++) begin
         issue_instr(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), 1'($urandom));
      end
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      rst_n = 1'b0; instr = '0; instr_valid = 1'b0; ex_ready = 1'b0;
      res = '0; res_valid = 1'b0; dbg_addr = '0;
      for (int a = 0; a < 8; a++) m_rf[a] = 16'h0;
      @(negedge clk);
      test_reset();
      test_immediate();
      test_register_form();
      test_backpressure();
      test_r0();
      test_random();
      test_midop_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
